draw_sequencer: RTL and testbench

//  Parametrised frame sequencer: clears the screen, then draws up to NUM_CIRCLES circles from a

---
 rtl/draw_seq_pkg.sv | 21 ++
 rtl/draw_sequencer_circle.sv | 75 +++++++
 rtl/draw_sequencer_fillscreen.sv | 37 +++
 rtl/draw_sequencer_shape_table.sv | 37 +++
 rtl/draw_sequencer.sv | 127 ++++++++++++
 tb/tb_draw_sequencer.sv | 207 ++++++++++++++++++++
 6 files changed

// File: rtl/draw_seq_pkg.sv
// Shared types and screen geometry for the draw sequencer slice.
package draw_seq_pkg;
  localparam int SCREEN_W     = 160;
  localparam int SCREEN_H     = 120;
  localparam int PKG_X_W      = 8;
  localparam int PKG_Y_W      = 7;
  localparam int PKG_COLOUR_W = 3;
  localparam int PKG_R_W      = 8;

  typedef enum logic [2:0] {
    IDLE, FILL, FILL_REL, FETCH, CIRC, CIRC_REL, DONE
  } state_t;

  typedef struct packed {
    logic                    en;
    logic [PKG_X_W-1:0]      cx;
    logic [PKG_Y_W-1:0]      cy;
    logic [PKG_R_W-1:0]      r;
    logic [PKG_COLOUR_W-1:0] colour;
  } shape_t;
endpackage

// File: rtl/draw_sequencer_circle.sv
// Midpoint circle rasteriser: eight octant pixels per step, one pixel per cycle.
module circle #(
  parameter int X_W = 8,
  parameter int Y_W = 7,
  parameter int R_W = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [X_W-1:0] centre_x,
  input  logic [Y_W-1:0] centre_y,
  input  logic [R_W-1:0] radius,
  output logic           done,
  output logic [X_W-1:0] vga_x,
  output logic [Y_W-1:0] vga_y,
  output logic           vga_plot
);
  localparam int OW = R_W + 2;
  localparam int CW = R_W + 3;

  logic signed [OW-1:0] ox, oy, ox_n, oy_n;
  logic signed [CW-1:0] crit;
  logic [2:0]           oct;
  logic                 running, finished;

  assign ox_n     = ox - OW'(1);
  assign oy_n     = oy + OW'(1);
  assign finished = $signed(oy) > $signed(ox);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ox <= '0; oy <= '0; crit <= '0; oct <= '0;
      running <= 1'b0; done <= 1'b0;
    end else if (!start) begin
      running <= 1'b0;
      done    <= 1'b0;
    end else if (!running && !done) begin
      ox      <= OW'(radius);
      oy      <= '0;
      crit    <= CW'(1) - CW'(radius);
      oct     <= '0;
      running <= 1'b1;
    end else if (running) begin
      if (finished) begin
        running <= 1'b0;
        done    <= 1'b1;
      end else begin
        oct <= oct + 3'd1;
        if (oct == 3'd7) begin
          oy <= oy_n;
          if (crit[CW-1] || crit == '0) begin
            crit <= crit + (CW'(oy_n) <<< 1) + CW'(1);
          end else begin
            ox   <= ox_n;
            crit <= crit + ((CW'(oy_n) - CW'(ox_n)) <<< 1) + CW'(1);
          end
        end
      end
    end
  end

  always_comb begin
    vga_plot = running && !finished;
    unique case (oct)
      3'd0: begin vga_x = centre_x + X_W'(ox); vga_y = centre_y + Y_W'(oy); end
      3'd1: begin vga_x = centre_x + X_W'(oy); vga_y = centre_y + Y_W'(ox); end
      3'd2: begin vga_x = centre_x - X_W'(oy); vga_y = centre_y + Y_W'(ox); end
      3'd3: begin vga_x = centre_x - X_W'(ox); vga_y = centre_y + Y_W'(oy); end
      3'd4: begin vga_x = centre_x - X_W'(ox); vga_y = centre_y - Y_W'(oy); end
      3'd5: begin vga_x = centre_x - X_W'(oy); vga_y = centre_y - Y_W'(ox); end
      3'd6: begin vga_x = centre_x + X_W'(oy); vga_y = centre_y - Y_W'(ox); end
      default: begin vga_x = centre_x + X_W'(ox); vga_y = centre_y - Y_W'(oy); end
    endcase
  end
endmodule

// File: rtl/draw_sequencer_fillscreen.sv
// Column-major full-screen walker: one plot per cycle while start is held, then done.
module fillscreen
  import draw_seq_pkg::*;
#(
  parameter int X_W = 8,
  parameter int Y_W = 7
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  output logic           done,
  output logic [X_W-1:0] vga_x,
  output logic [Y_W-1:0] vga_y,
  output logic           vga_plot
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vga_x <= '0;
      vga_y <= '0;
      done  <= 1'b0;
    end else if (!start) begin
      vga_x <= '0;
      vga_y <= '0;
      done  <= 1'b0;
    end else if (!done) begin
      if (vga_y == Y_W'(SCREEN_H - 1)) begin
        vga_y <= '0;
        if (vga_x == X_W'(SCREEN_W - 1)) done <= 1'b1;
        else vga_x <= vga_x + X_W'(1);
      end else begin
        vga_y <= vga_y + Y_W'(1);
      end
    end
  end

  assign vga_plot = start && !done;
endmodule

// File: rtl/draw_sequencer_shape_table.sv
// Shape register file: one write port, one async read port; only enable bits are reset.
module shape_table
  import draw_seq_pkg::*;
#(
  parameter int NUM_CIRCLES = 4,
  parameter int IDX_W       = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [IDX_W-1:0] wr_idx,
  input  shape_t           wr_data,
  input  logic [IDX_W-1:0] rd_idx,
  output shape_t           rd_data
);
  localparam int DW = $bits(shape_t) - 1;

  logic          en_q [NUM_CIRCLES];
  logic [DW-1:0] data [NUM_CIRCLES];
  logic          wr_ok;

  assign wr_ok = we && (int'(wr_idx) < NUM_CIRCLES);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_CIRCLES; i++) en_q[i] <= 1'b0;
    end else if (wr_ok) begin
      en_q[wr_idx] <= wr_data.en;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) data[wr_idx] <= wr_data[DW-1:0];
  end

  assign rd_data = {en_q[rd_idx], data[rd_idx]};
endmodule

// File: rtl/draw_sequencer.sv
// Frame sequencer: fill screen, then draw each enabled table circle on one plot bus.
// Define DRAW_SEQ_CLIP_EN to suppress plots that land off the 160x120 screen.
module draw_sequencer
  import draw_seq_pkg::*;
#(
  parameter int X_W         = PKG_X_W,
  parameter int Y_W         = PKG_Y_W,
  parameter int COLOUR_W    = PKG_COLOUR_W,
  parameter int R_W         = PKG_R_W,
  parameter int NUM_CIRCLES = 4,
  parameter int IDX_W       = (NUM_CIRCLES > 1) ? $clog2(NUM_CIRCLES) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic [COLOUR_W-1:0] bg_colour,
  input  logic                cfg_we,
  input  logic [IDX_W-1:0]    cfg_idx,
  input  logic                cfg_en,
  input  logic [X_W-1:0]      cfg_cx,
  input  logic [Y_W-1:0]      cfg_cy,
  input  logic [R_W-1:0]      cfg_r,
  input  logic [COLOUR_W-1:0] cfg_colour,
  output logic                busy,
  output logic                done,
  output logic [IDX_W-1:0]    cur_idx,
  output logic [X_W-1:0]      vga_x,
  output logic [Y_W-1:0]      vga_y,
  output logic [COLOUR_W-1:0] vga_colour,
  output logic                vga_plot
);
  state_t              state;
  shape_t              wr_entry, rd_entry;
  logic [IDX_W-1:0]    scan_idx;
  logic [COLOUR_W-1:0] bg_q, snap_colour, last_colour;
  logic [X_W-1:0]      snap_cx, fill_x, circ_x, last_x;
  logic [Y_W-1:0]      snap_cy, fill_y, circ_y, last_y;
  logic [R_W-1:0]      snap_r;
  logic                fill_done, fill_plot, circ_done, circ_plot, raw_plot, last_scan;

  assign wr_entry  = '{en: cfg_en, cx: cfg_cx, cy: cfg_cy, r: cfg_r, colour: cfg_colour};
  assign last_scan = (scan_idx == IDX_W'(NUM_CIRCLES - 1));

  shape_table #(.NUM_CIRCLES(NUM_CIRCLES), .IDX_W(IDX_W)) u_tbl (
    .clk(clk), .rst_n(rst_n), .we(cfg_we), .wr_idx(cfg_idx), .wr_data(wr_entry),
    .rd_idx(scan_idx), .rd_data(rd_entry)
  );

  fillscreen #(.X_W(X_W), .Y_W(Y_W)) u_fill (
    .clk(clk), .rst_n(rst_n), .start(state == FILL), .done(fill_done),
    .vga_x(fill_x), .vga_y(fill_y), .vga_plot(fill_plot)
  );

  circle #(.X_W(X_W), .Y_W(Y_W), .R_W(R_W)) u_circ (
    .clk(clk), .rst_n(rst_n), .start(state == CIRC), .centre_x(snap_cx), .centre_y(snap_cy),
    .radius(snap_r), .done(circ_done), .vga_x(circ_x), .vga_y(circ_y), .vga_plot(circ_plot)
  );

  // scan_idx walks the table; cur_idx only follows it when an entry is actually drawn
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE; busy <= 1'b0; done <= 1'b0; cur_idx <= '0; scan_idx <= '0;
      bg_q <= '0; snap_cx <= '0; snap_cy <= '0; snap_r <= '0; snap_colour <= '0;
    end else if (abort && busy) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (start) begin
          bg_q <= bg_colour; cur_idx <= '0; scan_idx <= '0; busy <= 1'b1; state <= FILL;
        end
        FILL:     if (fill_done) state <= FILL_REL;
        FILL_REL: state <= FETCH;
        FETCH: begin
          if (rd_entry.en) begin
            snap_cx <= rd_entry.cx; snap_cy <= rd_entry.cy;
            snap_r  <= rd_entry.r;  snap_colour <= rd_entry.colour;
            cur_idx <= scan_idx;    state <= CIRC;
          end else if (last_scan) begin
            state <= DONE; busy <= 1'b0; done <= 1'b1;
          end else begin
            scan_idx <= scan_idx + IDX_W'(1);
          end
        end
        CIRC: if (circ_done) state <= CIRC_REL;
        CIRC_REL: begin
          if (last_scan) begin
            state <= DONE; busy <= 1'b0; done <= 1'b1;
          end else begin
            scan_idx <= scan_idx + IDX_W'(1);
            state    <= FETCH;
          end
        end
        DONE: if (!start) begin
          state <= IDLE;
          done  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    vga_x = last_x; vga_y = last_y; vga_colour = last_colour; raw_plot = 1'b0;
    if (state == FILL) begin
      vga_x = fill_x; vga_y = fill_y; vga_colour = bg_q; raw_plot = fill_plot;
    end else if (state == CIRC) begin
      vga_x = circ_x; vga_y = circ_y; vga_colour = snap_colour; raw_plot = circ_plot;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_x <= '0; last_y <= '0; last_colour <= '0;
    end else if (state == FILL || state == CIRC) begin
      last_x <= vga_x; last_y <= vga_y; last_colour <= vga_colour;
    end
  end

`ifdef DRAW_SEQ_CLIP_EN
  assign vga_plot = raw_plot && (vga_x < X_W'(SCREEN_W)) && (vga_y < Y_W'(SCREEN_H));
`else
  assign vga_plot = raw_plot;
`endif
endmodule

// File: tb/tb_draw_sequencer.sv
// Self-checking bench: frames are checked against a pixel-set model of fill plus midpoint circles.
module tb_draw_sequencer;
  logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0;
  logic [2:0] bg_colour = '0, cfg_colour = '0;
  logic       cfg_we = 1'b0, cfg_en = 1'b0;
  logic [1:0] cfg_idx = '0;
  logic [7:0] cfg_cx = '0, cfg_r = '0;
  logic [6:0] cfg_cy = '0;
  logic       busy, done, vga_plot;
  logic [1:0] cur_idx;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;

  draw_sequencer #(.NUM_CIRCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .bg_colour(bg_colour),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_en(cfg_en), .cfg_cx(cfg_cx), .cfg_cy(cfg_cy),
    .cfg_r(cfg_r), .cfg_colour(cfg_colour), .busy(busy), .done(done), .cur_idx(cur_idx),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot)
  );

  always #5 clk = ~clk;

  typedef struct {int x; int y; int c;} plot_t;
  plot_t plot_q[$];
  always @(negedge clk) if (rst_n && vga_plot) plot_q.push_back('{int'(vga_x), int'(vga_y), int'(vga_colour)});

  int checks = 0, errors = 0;
  int e_cx[4], e_cy[4], e_r[4], e_c[4];
  int e_n = 0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic write_entry(int idx, bit en, int cx, int cy, int r, int c);
    @(negedge clk);
    cfg_we = 1'b1; cfg_idx = idx[1:0]; cfg_en = en;
    cfg_cx = cx[7:0]; cfg_cy = cy[6:0]; cfg_r = r[7:0]; cfg_colour = c[2:0];
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic add_circle(int cx, int cy, int r, int c);
    e_cx[e_n] = cx; e_cy[e_n] = cy; e_r[e_n] = r; e_c[e_n] = c; e_n++;
  endtask

  task automatic wait_done(string tag);
    int n = 0;
    while (done !== 1'b1 && n < 25000) begin @(negedge clk); n++; end
    chk({tag, "_done_in_time"}, done, 1);
  endtask

  task automatic wait_plots(string tag, int cnt);
    int n = 0;
    while (plot_q.size() <= cnt && n < 25000) begin @(negedge clk); n++; end
    chk({tag, "_reached_circle"}, plot_q.size() > cnt, 1);
  endtask

  function automatic bit visible(int x, int y);
`ifdef DRAW_SEQ_CLIP_EN
    return (x < 160) && (y < 120);
`else
    return 1'b1;
`endif
  endfunction

  // Fill phase: every on-screen pixel exactly once in bg; then each circle's pixel multiset in order.
  task automatic check_frame(string tag, int bg);
    bit seen [19200];
    int cnt [int];
    int distinct = 0, fbad = 0, pos, off_obs = 0, off_exp = 0;
    for (int i = 0; i < plot_q.size() && i < 19200; i++) begin
      if (plot_q[i].x < 160 && plot_q[i].y < 120 && plot_q[i].c == bg) begin
        if (!seen[plot_q[i].x * 120 + plot_q[i].y]) begin
          seen[plot_q[i].x * 120 + plot_q[i].y] = 1'b1; distinct++;
        end
      end else fbad++;
    end
    chk({tag, "_fill_pixels"}, distinct, 19200);
    chk({tag, "_fill_bad"}, fbad, 0);
    pos = 19200;
    for (int k = 0; k < e_n; k++) begin
      int x = e_r[k], y = 0, d = 1 - e_r[k], n = 0, cbad = 0;
      cnt.delete();
      while (y <= x) begin
        for (int s = 0; s < 8; s++) begin
          int sx = (s & 1) ? -1 : 1;
          int sy = (s & 2) ? -1 : 1;
          int px = (s & 4) ? e_cx[k] + sx * y : e_cx[k] + sx * x;
          int py = (s & 4) ? e_cy[k] + sy * x : e_cy[k] + sy * y;
          px = px & 255; py = py & 127;
          if (visible(px, py)) begin
            cnt[px * 128 + py]++; n++;
            if (px >= 160 || py >= 120) off_exp++;
          end
        end
        y++;
        if (d <= 0) d += 2 * y + 1;
        else begin x--; d += 2 * (y - x) + 1; end
      end
      for (int j = 0; j < n; j++) begin
        if (pos < plot_q.size()) begin
          int key = plot_q[pos].x * 128 + plot_q[pos].y;
          if (plot_q[pos].c == e_c[k] && cnt.exists(key) && cnt[key] > 0) cnt[key]--;
          else cbad++;
          if (plot_q[pos].x >= 160 || plot_q[pos].y >= 120) off_obs++;
        end else cbad++;
        pos++;
      end
      chk($sformatf("%s_circle%0d_bad", tag, k), cbad, 0);
    end
    chk({tag, "_total_plots"}, plot_q.size(), pos);
    chk({tag, "_offscreen_plots"}, off_obs, off_exp);
  endtask

  initial begin
    int cx0, cy0, r0, c0, cy3, c3, bg, cx1, cy1, r1, c1, sz;
    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0); chk("rst_done", done, 0); chk("rst_cur_idx", cur_idx, 0);
    chk("rst_plot", vga_plot, 0); chk("rst_x", vga_x, 0); chk("rst_y", vga_y, 0);
    chk("rst_colour", vga_colour, 0);
    rst_n = 1'b1;

    // Reset mid-fill; entries 0,1,3 enabled beforehand must come back disabled
    write_entry(0, 1, 30, 30, 5, 1);
    write_entry(1, 1, 60, 30, 5, 1);
    write_entry(3, 1, 90, 30, 5, 1);
    @(negedge clk); start = 1'b1; bg_colour = 3'd6;
    repeat (50) @(negedge clk);
    chk("fill_busy", busy, 1); chk("fill_plot_active", vga_plot, 1);
    chk("fill_colour", vga_colour, 6);
    rst_n = 1'b0; start = 1'b0;
    #1;
    chk("midrst_plot", vga_plot, 0); chk("midrst_busy", busy, 0);
    @(negedge clk); rst_n = 1'b1;

    // Frame 1: only entry 2 (80,60,r40,colour 2), bg 0
    write_entry(2, 1, 80, 60, 40, 2);
    plot_q.delete(); e_n = 0; add_circle(80, 60, 40, 2);
    @(negedge clk); bg_colour = 3'd0; start = 1'b1;
    wait_done("f1");
    check_frame("f1", 0);
    chk("f1_cur_idx", cur_idx, 2); chk("f1_busy", busy, 0);
    sz = plot_q.size();
    repeat (5) @(negedge clk);
    chk("f1_no_retrigger_done", done, 1); chk("f1_no_retrigger_plots", plot_q.size(), sz);
    start = 1'b0;
    @(negedge clk);
    chk("f1_done_clears", done, 0);

    // Frame 2: entries 0 and 3; rewrite both while entry 0 is being drawn; entry 3 off the right edge
    cx0 = $urandom_range(30, 130); cy0 = $urandom_range(30, 90);
    r0 = $urandom_range(12, 28); c0 = $urandom_range(0, 7);
    cy3 = $urandom_range(45, 75); c3 = $urandom_range(0, 4);
    bg = $urandom_range(0, 7);
    write_entry(2, 0, 0, 0, 0, 0);
    write_entry(0, 1, cx0, cy0, r0, c0);
    write_entry(3, 1, 150, cy3, 40, c3);
    plot_q.delete(); e_n = 0;
    add_circle(cx0, cy0, r0, c0); add_circle(150, cy3, 40, 5);
    @(negedge clk); bg_colour = bg[2:0]; start = 1'b1;
    wait_plots("f2", 19203);
    chk("f2_cur_idx_during", cur_idx, 0); chk("f2_busy_during", busy, 1);
    write_entry(0, 1, cx0, cy0, 10, c0);
    write_entry(3, 1, 150, cy3, 40, 5);
    wait_done("f2");
    check_frame("f2", bg);
    chk("f2_cur_idx", cur_idx, 3);
    start = 1'b0;

    // Frame 3: abort during circle of entry 1
    cx1 = $urandom_range(30, 130); cy1 = $urandom_range(30, 90);
    r1 = $urandom_range(10, 30); c1 = $urandom_range(0, 7);
    write_entry(0, 0, 0, 0, 0, 0);
    write_entry(3, 0, 0, 0, 0, 0);
    write_entry(1, 1, cx1, cy1, r1, c1);
    plot_q.delete();
    @(negedge clk); bg_colour = 3'd1; start = 1'b1;
    wait_plots("f3", 19205);
    chk("f3_cur_idx", cur_idx, 1);
    abort = 1'b1; start = 1'b0;
    @(negedge clk); abort = 1'b0;
    chk("abort_plot", vga_plot, 0); chk("abort_busy", busy, 0); chk("abort_done", done, 0);
    sz = plot_q.size();
    repeat (3) @(negedge clk);
    chk("abort_quiet", plot_q.size(), sz);

    // Frame 4: all disabled, redraw from fill with zero circle plots
    write_entry(1, 0, 0, 0, 0, 0);
    plot_q.delete(); e_n = 0;
    @(negedge clk); bg_colour = 3'd4; start = 1'b1;
    wait_done("f4");
    check_frame("f4", 4);
    chk("f4_cur_idx", cur_idx, 0); chk("f4_busy", busy, 0);
    start = 1'b0;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
